// File: rtl/msk_mixcolumn_pipe_pkg.sv
// Shared constants and helpers for the masked MixColumns pipeline.
//   AES_POLY : reduction constant used by xtime
//   COL_W    : unshared column width in bits
//   bus_idx  : maps (unshared bit, share) to an index on a bit-interleaved bus
package msk_mixcolumn_pipe_pkg;

    localparam logic [7:0]  AES_POLY = 8'h1B;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned N_ROWS   = 4;

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_INV = 1'b1
    } mc_mode_e;

    // Share j of unshared bit b sits at b*d + j.
    function automatic int unsigned bus_idx(input int unsigned bit_i,
                                            input int unsigned share,
                                            input int unsigned d);
        return bit_i * d + share;
    endfunction

endpackage

// File: rtl/msk_mixcolumn_pipe_if.sv
// Column stream interface of the masked MixColumns pipeline.
//   sh_in/in_inv/in_valid/in_ready    : upstream column handshake
//   sh_out/out_last/out_valid/out_ready : downstream column handshake
// master = producer/consumer side (bench or neighbouring stages), slave = the unit.
interface msk_mixcolumn_pipe_if
    import msk_mixcolumn_pipe_pkg::*;
#(
    parameter int unsigned d = 2
);
    localparam int unsigned W = COL_W * d;

    logic [W-1:0] sh_in;
    logic         in_inv;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sh_out;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (
        output sh_in, in_inv, in_valid, out_ready,
        input  in_ready, sh_out, out_valid, out_last
    );

    modport slave (
        input  sh_in, in_inv, in_valid, out_ready,
        output in_ready, sh_out, out_valid, out_last
    );

endinterface

// File: rtl/msk_xtime_sharewise.sv
// Share-wise GF(2^8) multiply-by-2 on one bit-interleaved masked byte.
//   i_x   : 8*d-bit masked byte (bit b, share j at b*d+j)
//   o_x_c : combinational xtime of every share, same layout
// Each output bit uses only bits of its own share.
module msk_xtime_sharewise
    import msk_mixcolumn_pipe_pkg::*;
#(
    parameter int unsigned d = 2
) (
    input  logic [BYTE_W*d-1:0] i_x,
    output logic [BYTE_W*d-1:0] o_x_c
);

    for (genvar j = 0; j < int'(d); j++) begin : g_share
        for (genvar b = 0; b < int'(BYTE_W); b++) begin : g_bit
            if (b == 0) begin : g_lsb
                assign o_x_c[bus_idx(0, j, d)] =
                    AES_POLY[0] & i_x[bus_idx(BYTE_W - 1, j, d)];
            end else begin : g_upper
                assign o_x_c[bus_idx(b, j, d)] =
                    i_x[bus_idx(b - 1, j, d)] ^
                    (AES_POLY[b] & i_x[bus_idx(BYTE_W - 1, j, d)]);
            end
        end
    end

endmodule

// File: rtl/msk_mixcolumn_pipe.sv
// Masked AES MixColumns / InvMixColumns column stage with a valid/ready
// output register and a column counter marking column 3 of each state.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of msk_mixcolumn_pipe_if (column in, column out)
// Purely linear and share-wise: no randomness, no cross-share logic.
module msk_mixcolumn_pipe
    import msk_mixcolumn_pipe_pkg::*;
#(
    parameter int unsigned d = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    msk_mixcolumn_pipe_if.slave   bus
);

    localparam int unsigned BW = BYTE_W * d;
    localparam int unsigned CW = COL_W * d;

    logic [BW-1:0] w_a [N_ROWS];
    logic [BW-1:0] w_b [N_ROWS];
    logic [BW-1:0] w_t [N_ROWS];
    logic [BW-1:0] w_r [N_ROWS];
    logic [BW-1:0] w_s02, w_s13;
    logic [BW-1:0] w_u2, w_u4, w_v2, w_v4;
    logic [BW-1:0] w_u, w_v;
    logic [BW-1:0] w_gate;
    logic [CW-1:0] w_mix;
    mc_mode_e      w_mode;
    logic          w_in_hs;
    logic          w_out_hs;

    logic [CW-1:0] r_out_q;
    logic          r_out_valid;
    logic          r_out_last;
    logic [1:0]    r_col_cnt;

    // Bytes are contiguous BW-bit slices of the interleaved bus.
    for (genvar k = 0; k < int'(N_ROWS); k++) begin : g_slice
        assign w_a[k] = bus.sh_in[bus_idx(BYTE_W * k, 0, d) +: BW];
        assign w_mix[bus_idx(BYTE_W * k, 0, d) +: BW] = w_r[k];
    end

    // Inverse pre-step: 4*(a0^a2) and 4*(a1^a3), gated off in forward mode.
    assign w_s02 = w_a[0] ^ w_a[2];
    assign w_s13 = w_a[1] ^ w_a[3];

    msk_xtime_sharewise #(.d(d)) u_xt_u2 (.i_x(w_s02), .o_x_c(w_u2));
    msk_xtime_sharewise #(.d(d)) u_xt_u4 (.i_x(w_u2),  .o_x_c(w_u4));
    msk_xtime_sharewise #(.d(d)) u_xt_v2 (.i_x(w_s13), .o_x_c(w_v2));
    msk_xtime_sharewise #(.d(d)) u_xt_v4 (.i_x(w_v2),  .o_x_c(w_v4));

    assign w_mode = mc_mode_e'(bus.in_inv);
    assign w_gate = {BW{w_mode == MODE_INV}};
    assign w_u    = w_u4 & w_gate;
    assign w_v    = w_v4 & w_gate;

    // Shared forward network: r_k = 2b_k ^ 3b_{k+1} ^ b_{k+2} ^ b_{k+3}.
    for (genvar k = 0; k < int'(N_ROWS); k++) begin : g_fwd
        if ((k % 2) == 0) begin : g_even
            assign w_b[k] = w_a[k] ^ w_u;
        end else begin : g_odd
            assign w_b[k] = w_a[k] ^ w_v;
        end

        msk_xtime_sharewise #(.d(d)) u_xt_fwd (.i_x(w_b[k]), .o_x_c(w_t[k]));

        assign w_r[k] = w_t[k] ^ w_t[(k + 1) % 4] ^ w_b[(k + 1) % 4] ^
                        w_b[(k + 2) % 4] ^ w_b[(k + 3) % 4];
    end

    // Handshakes; backpressure passes straight through (no skid buffer).
    assign bus.in_ready  = !r_out_valid || bus.out_ready;
    assign w_in_hs       = bus.in_valid && bus.in_ready;
    assign w_out_hs      = r_out_valid && bus.out_ready;
    assign bus.sh_out    = r_out_q;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;

    // Output register and column counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_col_cnt   <= 2'd0;
        end else begin
            if (w_in_hs) begin
                r_out_q     <= w_mix;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_col_cnt == 2'd3);
                r_col_cnt   <= r_col_cnt + 2'd1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_msk_mixcolumn_pipe.sv
// Scoreboard bench for msk_mixcolumn_pipe, run on d = 1, 2, 3, 5 in lockstep.
module tb_msk_mixcolumn_pipe;
    import msk_mixcolumn_pipe_pkg::*;

    localparam int unsigned N_INST = 4;
    localparam int unsigned MAX_W  = 32 * 5;

    typedef struct packed {
        logic [31:0] col;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             in_valid;
    logic             in_inv;
    logic             out_ready;
    logic [31:0]      in_col;
    logic [MAX_W-1:0] rnd;

    logic [N_INST-1:0]            ov;
    logic [N_INST-1:0]            ir;
    logic [N_INST-1:0]            ol;
    logic [N_INST-1:0][31:0]      out_plain;
    logic [N_INST-1:0][MAX_W-1:0] raw;

    exp_t exp_q[$];
    logic [1:0] model_cnt;
    int checks;
    int errors;
    int n_pushed;
    int n_popped;
    int n_flushed;
    bit rand_bp;

    for (genvar g = 0; g < int'(N_INST); g++) begin : g_inst
        localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 5;

        msk_mixcolumn_pipe_if #(.d(D)) bus ();

        msk_mixcolumn_pipe #(.d(D)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        logic [31:0] plain;

        assign bus.in_valid  = in_valid;
        assign bus.in_inv    = in_inv;
        assign bus.out_ready = out_ready;

        // Mask each bit: d-1 random shares, last share completes the XOR.
        always_comb begin
            logic acc;
            bus.sh_in = '0;
            for (int b = 0; b < 32; b++) begin
                acc = in_col[b];
                for (int j = 0; j < int'(D) - 1; j++) begin
                    bus.sh_in[b * int'(D) + j] = rnd[b * int'(D) + j];
                    acc = acc ^ rnd[b * int'(D) + j];
                end
                bus.sh_in[b * int'(D) + int'(D) - 1] = acc;
            end
        end

        // Unmask by XOR of all shares.
        always_comb begin
            plain = '0;
            for (int b = 0; b < 32; b++)
                for (int j = 0; j < int'(D); j++)
                    plain[b] = plain[b] ^ bus.sh_out[b * int'(D) + j];
        end

        assign out_plain[g] = plain;
        assign raw[g]       = MAX_W'(bus.sh_out);
        assign ov[g]        = bus.out_valid;
        assign ir[g]        = bus.in_ready;
        assign ol[g]        = bus.out_last;
    end

    // Reference: GF(2^8) multiply and matrix-by-column product.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] ref_mix(input logic [31:0] col, input logic inv);
        logic [7:0]  a [4];
        logic [7:0]  c [4];
        logic [31:0] r;
        for (int k = 0; k < 4; k++) a[k] = col[8 * k +: 8];
        if (inv) begin
            c[0] = 8'h0e; c[1] = 8'h0b; c[2] = 8'h0d; c[3] = 8'h09;
        end else begin
            c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01;
        end
        r = '0;
        for (int k = 0; k < 4; k++)
            for (int m = 0; m < 4; m++)
                r[8 * k +: 8] = r[8 * k +: 8] ^ gmul(a[(k + m) % 4], c[m]);
        return r;
    endfunction

    task automatic check(input bit ok, input string name,
                         input logic [MAX_W-1:0] act, input logic [MAX_W-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one column (fresh masks) and wait for acceptance; ends at posedge+1.
    task automatic send(input logic [31:0] col, input logic inv, input logic [31:0] exp_col);
        bit   hs;
        int   cyc;
        exp_t e;
        in_valid = 1'b1;
        in_col   = col;
        in_inv   = inv;
        rnd      = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        hs  = 1'b0;
        cyc = 0;
        while (!hs && cyc < 50) begin
            @(negedge clk);
            hs = ir[0];
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!hs) begin
            check(1'b0, "accept_timeout", MAX_W'(cyc), MAX_W'(50));
        end else begin
            e.col  = exp_col;
            e.last = (model_cnt == 2'd3);
            exp_q.push_back(e);
            model_cnt = model_cnt + 2'd1;
            n_pushed++;
            check(ov == 4'hF, "valid_after_accept", MAX_W'(ov), MAX_W'(4'hF));
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Asynchronous reset applied mid-cycle; model restarts numbering.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check(ov == 4'h0, "reset_out_valid", MAX_W'(ov), MAX_W'(0));
        check(ir == 4'hF, "reset_in_ready", MAX_W'(ir), MAX_W'(4'hF));
        n_flushed += exp_q.size();
        exp_q.delete();
        model_cnt = 2'd0;
        in_valid  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ov[0] && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_output", MAX_W'(out_plain[0]), MAX_W'(0));
                end else begin
                    e = exp_q.pop_front();
                    n_popped++;
                    for (int g = 0; g < int'(N_INST); g++) begin
                        check(out_plain[g] == e.col, $sformatf("data_inst%0d", g),
                              MAX_W'(out_plain[g]), MAX_W'(e.col));
                        check(ol[g] == e.last, $sformatf("last_inst%0d", g),
                              MAX_W'(ol[g]), MAX_W'(e.last));
                    end
                end
            end
        end
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [N_INST-1:0][MAX_W-1:0] snap_raw;
        logic [N_INST-1:0]            snap_ol;
        logic [31:0]                  c;
        logic                         m;
        int                           cyc;

        checks = 0; errors = 0; n_pushed = 0; n_popped = 0; n_flushed = 0;
        rand_bp = 1'b0; model_cnt = 2'd0;
        rst_n = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b1;
        in_col = '0; rnd = '0;

        // Reset values.
        #2;
        rst_n = 1'b0;
        #1;
        check(ov == 4'h0, "rst_out_valid", MAX_W'(ov), MAX_W'(0));
        check(ol == 4'h0, "rst_out_last", MAX_W'(ol), MAX_W'(0));
        check(ir == 4'hF, "rst_in_ready", MAX_W'(ir), MAX_W'(4'hF));
        for (int g = 0; g < int'(N_INST); g++)
            check(raw[g] == '0, "rst_out_q", raw[g], '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed forward / inverse vectors, each from idle.
        check(ov == 4'h0, "idle_before_fwd", MAX_W'(ov), MAX_W'(0));
        send({8'h45, 8'h53, 8'h13, 8'hdb}, 1'b0, {8'hbc, 8'ha1, 8'h4d, 8'h8e});
        idle(2);
        check(ov == 4'h0, "idle_before_fwd2", MAX_W'(ov), MAX_W'(0));
        send({8'hd5, 8'hd4, 8'hd4, 8'hd4}, 1'b0, {8'hd6, 8'hd7, 8'hd5, 8'hd5});
        idle(2);
        send(32'hc6c6c6c6, 1'b0, 32'hc6c6c6c6);
        idle(2);
        send({8'hbc, 8'ha1, 8'h4d, 8'h8e}, 1'b1, {8'h45, 8'h53, 8'h13, 8'hdb});
        idle(2);

        // Mode alternating every column at full rate.
        for (int i = 0; i < 8; i++) begin
            c = $urandom();
            m = 1'(i % 2);
            send(c, m, ref_mix(c, m));
        end
        idle(2);

        // 12 back-to-back columns from a fresh count: last on 4, 8, 12.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            c = $urandom();
            m = 1'($urandom_range(0, 1));
            send(c, m, ref_mix(c, m));
        end
        idle(2);

        // Backpressure: 5 stalled cycles with a column waiting.
        c = $urandom();
        send(c, 1'b0, ref_mix(c, 1'b0));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        c = $urandom();
        in_col = c;
        in_inv = 1'b1;
        snap_raw = raw;
        snap_ol  = ol;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(ir == 4'h0, "stall_in_ready", MAX_W'(ir), MAX_W'(0));
            check(ov == 4'hF, "stall_out_valid", MAX_W'(ov), MAX_W'(4'hF));
            check(raw == snap_raw, "stall_sh_out", raw[N_INST-1], snap_raw[N_INST-1]);
            check(ol == snap_ol, "stall_out_last", MAX_W'(ol), MAX_W'(snap_ol));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(c, 1'b1, ref_mix(c, 1'b1));
        idle(2);

        // Reset while column 2 is being offered; numbering restarts at 0.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            c = $urandom();
            send(c, 1'b0, ref_mix(c, 1'b0));
        end
        in_col   = $urandom();
        in_valid = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            c = $urandom();
            m = 1'($urandom_range(0, 1));
            send(c, m, ref_mix(c, m));
        end
        idle(2);

        // Random traffic with random gaps and random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            c = $urandom();
            m = 1'($urandom_range(0, 1));
            send(c, m, ref_mix(c, m));
        end
        rand_bp = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Drain and account for every column.
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        idle(2);
        check(exp_q.size() == 0, "drain_empty", MAX_W'(exp_q.size()), MAX_W'(0));
        check(n_pushed == n_popped + n_flushed, "column_count",
              MAX_W'(n_popped + n_flushed), MAX_W'(n_pushed));
        check(ov == 4'h0, "final_idle", MAX_W'(ov), MAX_W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msk_mixcolumn_pipe.md
# msk_mixcolumn_pipe

Pipelined, share-wise masked AES MixColumns/InvMixColumns unit operating on one 32-bit state column per transaction, generalised over the masking order `d`. It sits between the masked S-box/ShiftRows datapath and the AddRoundKey stage of the 32-bit-per-cycle masked AES core. It adds a valid/ready elastic register stage, a per-column direction select and a column counter that flags the last column of each 128-bit state. All operations are linear and share-wise, so no randomness is consumed.

## Interface
- `d`, default 2, number of shares (≥1).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous reset, active low.
- `sh_in`  in  32*d  masked input column, bit-interleaved: unshared bit b (0..31), share j at index b*d+j; byte k = unshared bits 8k+7..8k, byte 0 = row 0.
- `in_inv`  in  1  0 = MixColumns, 1 = InvMixColumns; sampled with `sh_in`.
- `in_valid`  in  1  input column valid.
- `in_ready`  out  1  unit can accept a column.
- `sh_out`  out  32*d  masked result column, same encoding as `sh_in`.
- `out_valid`  out  1  `sh_out` valid.
- `out_ready`  in  1  downstream accepts.
- `out_last`  out  1  output column is column 3 of its state.

## Operation
- Input handshake: `in_valid && in_ready` at a rising edge. Output handshake: `out_valid && out_ready`.
- Each share is processed independently. Share j of the output depends only on share j of the input. No gate or register combines bits of different shares.
- Forward, per share, bytes a0..a3: r_k = 2·a_k ⊕ 3·a_{k+1} ⊕ a_{k+2} ⊕ a_{k+3}, with indices mod 4.
- xtime(x) = (x<<1)[7:0] ⊕ (0x1B if x[7]).
- 3·x = xtime(x) ⊕ x.
- Inverse, per share:
  - u = xtime(xtime(a0⊕a2)), v = xtime(xtime(a1⊕a3)).
  - a0⊕=u, a1⊕=v, a2⊕=u, a3⊕=v.
  - Then apply forward MixColumns.
  - The same circuit is shared with the forward path; `in_inv` gates u and v to zero in forward mode.
- Computation is combinational on the input side. The result is captured in output register `out_q` (32*d bits).
- Column counter `col_cnt` (2 bits) increments on each input handshake and wraps 3→0. `out_last` is registered with the data and set when the accepted column had `col_cnt==3`.
- `in_ready = !out_valid || out_ready` (combinational pass-through of backpressure; no skid buffer).
- On an input handshake: `out_q`, `out_last` and `out_valid` are loaded.
- On an output handshake with no input handshake: `out_valid` clears, and `out_q` holds its value (no share-value zeroing required).
- Simultaneous input and output handshake: the new column replaces the old one, `out_valid` stays 1, and the counter advances.

## Timing
- Reset values (asynchronous assertion): `out_valid`=0, `out_last`=0, `out_q`=0, `col_cnt`=0. `in_ready`=1 follows.
- Reset deassertion takes effect at the next rising edge. Reset mid-operation discards any held column and restarts column numbering at 0.
- Latency: 1 cycle. A column accepted at edge t is visible with `out_valid`=1 after edge t.
- Throughput: 1 column/cycle while `out_ready`=1.
- Stall: while `out_valid && !out_ready`, `sh_out`, `out_last` and `out_valid` are stable and `in_ready`=0.
- `in_inv` may change every column. Mode is never registered separately from data.

## Structure
- Shared package holds:
  - `AES_POLY = 8'h1B`
  - column width constant 32
  - helper function mapping (bit, share) to a bus index
- One sub-module, `msk_xtime_sharewise`: combinational, parameter `d`, 8*d-bit in/out. It is instantiated for the 2·x terms and twice in series for the 4·x inverse terms.
- The top holds the share (de)interleaving, the XOR network, the registers, the counter and the handshake.

## Test plan
- Reference comparison: the bench recombines shares by XOR of all d shares and compares against the unmasked reference. Random masks are used for every test and for d ∈ {1,2,3,5}.
- Forward, bytes 0..3 = db 13 53 45 → 8e 4d a1 bc. Also d4 d4 d4 d5 → d5 d5 d7 d6, and c6 c6 c6 c6 → c6 c6 c6 c6, with out_valid exactly 1 cycle after acceptance.
- Inverse, `in_inv`=1, 8e 4d a1 bc → db 13 53 45. Alternating the mode every column at full rate must give the correct result for each column.
- Streaming: 12 back-to-back columns with `out_ready`=1 → 12 outputs in order, and `out_last` high on outputs 4, 8 and 12 only.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `in_ready`=0 and `sh_out` stable throughout. On release, no column is lost or duplicated.
- Reset: assert `rst_n`=0 asynchronously mid-stream at column 2 → `out_valid`=0 immediately. The next accepted column is numbered 0, and `out_last` asserts on the 4th column after reset.
